player_ctrl: RTL
================

PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 SHALL have parameter width_p, default 10, position bus width.
REQ-002 SHALL have parameter max_lives_p, default 3, lives saturation ceiling.
REQ-003 SHALL have parameter start_lives_p, default 2, lives loaded at reset and on new game.
REQ-004 SHALL have parameter step_p, default 5, pixels moved per frame.
REQ-005 SHALL have parameter ship_width_p, default 40, ship width in pixels.
REQ-006 SHALL have parameters left_border_p / right_border_p, defaults 9 / 629, movement limits.
REQ-007 SHALL have parameter start_pos_p, default 249, left edge after reset or resume.
REQ-008 SHALL have parameter cooldown_p, default 8, frames between accepted shots.
REQ-009 SHALL have parameter flash_period_p, default 8, frames per visibility toggle.
REQ-010 SHALL have ports: clk_i in 1, clock; reset_ni in 1, asynchronous active-low reset.
REQ-011 SHALL have input ports, all width 1: frame_i (one-cycle pulse per frame), move_left_i, move_right_i, shoot_i, hit_i, add_life_i, shot_ready_i.
REQ-012 SHALL have output ports: shot_valid_o 1, shot_x_o width_p (shot spawn column), alive_o 1, paused_o 1, visible_o 1.
REQ-013 SHALL have output ports: pos_left_o width_p, pos_right_o width_p, lives_o $clog2(max_lives_p+1), state_o 3.

Function
REQ-014 SHALL implement states IDLE, LEFT, RIGHT, HIT, DEAD, encoded on state_o as 0..4.
REQ-015 In IDLE/LEFT/RIGHT: hit_i has top priority; left-only -> LEFT; right-only -> RIGHT; neither or both -> IDLE.
REQ-016 On hit_i in IDLE/LEFT/RIGHT: lives_o>0 -> lives_o decrements, next state HIT; lives_o==0 -> next state DEAD.
REQ-017 In LEFT on frame_i: pos_left = max(pos_left-step_p, left_border_p), computed without underflow.
REQ-018 In RIGHT on frame_i: pos_left = min(pos_left+step_p, right_border_p-ship_width_p).
REQ-019 pos_right_o SHALL be pos_left_o+ship_width_p, combinational.
REQ-020 Shot request: shoot_i, state IDLE/LEFT/RIGHT, cooldown==0, shot_valid_o low, no hit_i -> shot_valid_o high next cycle, shot_x_o latched to pos_left+ship_width_p/2.
REQ-021 shot_valid_o and shot_x_o SHALL hold stable until the cycle shot_valid_o & shot_ready_i; then shot_valid_o drops and cooldown loads cooldown_p.
REQ-022 Cooldown SHALL decrement by one per frame_i, saturating at 0.
REQ-023 Entering HIT or DEAD SHALL clear shot_valid_o (pending shot dropped).
REQ-024 In HIT: paused_o=1, position frozen; shoot_i -> pos_left=start_pos_p, cooldown=cooldown_p, next state per REQ-015 move decode.
REQ-025 In DEAD: alive_o=0; shoot_i -> lives_o=start_lives_p, pos_left=start_pos_p, cooldown=cooldown_p, next state IDLE.
REQ-026 add_life_i & frame_i outside DEAD SHALL increment lives_o, saturating at max_lives_p.
REQ-027 Same-cycle hit_i and add_life_i: hit applies, no increment.
REQ-028 Unencoded state SHALL recover to IDLE next cycle with pos_left=start_pos_p.
REQ-029 alive_o=1 in all states except DEAD; paused_o=1 only in HIT.

Reset
REQ-030 reset_ni low SHALL asynchronously force: state IDLE, pos_left start_pos_p, lives_o start_lives_p, cooldown 0, shot_valid_o 0, shot_x_o 0, visible_o 1, flash counter 0.
REQ-031 Reset release SHALL be sampled synchronously; first transition on the following rising edge.

Configuration
REQ-032 Macro PLAYER_CTRL_FLASH_EN defined: in HIT visible_o toggles every flash_period_p frame_i pulses, forced 1 on leaving HIT.
REQ-033 PLAYER_CTRL_FLASH_EN undefined: visible_o = alive_o, no flash counter logic.

Verification
REQ-034 Reset, hold move_left_i 60 frames -> pos_left_o reaches 9 after 48 frames and holds 9, pos_right_o 49.
REQ-035 shoot_i at pos_left 249, shot_ready_i low 3 cycles -> shot_valid_o high 4 cycles, shot_x_o 269; re-shoot blocked until 8 frames after handshake.
REQ-036 hit_i with lives 2 -> state HIT, lives 1, paused_o 1; shoot_i -> IDLE, pos_left 249.
REQ-037 hit_i with lives 0 -> DEAD, alive_o 0; shoot_i -> IDLE, lives 2.
REQ-038 add_life_i & frame_i four times from lives 2 -> lives 3 saturated; with hit_i same cycle -> lives decrements only.
REQ-039 Assert reset_ni mid-move with shot_valid_o high -> outputs at reset values without a clock edge.

Source files
------------

// File: rtl/player_ctrl.sv
// Player ship controller: movement FSM, lives, shot handshake with cooldown.
// Optional hit-flash blinking of visible_o is enabled by defining PLAYER_CTRL_FLASH_EN.
module player_ctrl #(
  parameter int width_p        = 10,
  parameter int max_lives_p    = 3,
  parameter int start_lives_p  = 2,
  parameter int step_p         = 5,
  parameter int ship_width_p   = 40,
  parameter int left_border_p  = 9,
  parameter int right_border_p = 629,
  parameter int start_pos_p    = 249,
  parameter int cooldown_p     = 8,
  parameter int flash_period_p = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               frame_i,
  input  logic                               move_left_i,
  input  logic                               move_right_i,
  input  logic                               shoot_i,
  input  logic                               hit_i,
  input  logic                               add_life_i,
  input  logic                               shot_ready_i,
  output logic                               shot_valid_o,
  output logic [width_p-1:0]                 shot_x_o,
  output logic                               alive_o,
  output logic                               paused_o,
  output logic                               visible_o,
  output logic [width_p-1:0]                 pos_left_o,
  output logic [width_p-1:0]                 pos_right_o,
  output logic [$clog2(max_lives_p+1)-1:0]   lives_o,
  output logic [2:0]                         state_o
);

  localparam int LW   = $clog2(max_lives_p+1);
  localparam int CW   = $clog2(cooldown_p+1);
  localparam int RMAX = right_border_p - ship_width_p;

  localparam logic [width_p-1:0] STEP_W  = width_p'(step_p);
  localparam logic [width_p-1:0] START_W = width_p'(start_pos_p);
  localparam logic [width_p-1:0] LB_W    = width_p'(left_border_p);
  localparam logic [width_p-1:0] RMAX_W  = width_p'(RMAX);
  localparam logic [width_p-1:0] SW_W    = width_p'(ship_width_p);
  localparam logic [width_p-1:0] HALF_W  = width_p'(ship_width_p / 2);
  localparam logic [LW-1:0]      MAXL_W  = LW'(max_lives_p);
  localparam logic [LW-1:0]      STARTL_W = LW'(start_lives_p);
  localparam logic [CW-1:0]      COOL_W  = CW'(cooldown_p);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    HIT   = 3'd3,
    DEAD  = 3'd4
  } state_e;

  state_e             state_q, state_d, move_st;
  logic [width_p-1:0] pos_q, pos_d;
  logic [width_p-1:0] shot_x_q, shot_x_d;
  logic [LW-1:0]      lives_q, lives_d;
  logic [CW-1:0]      cool_q, cool_d;
  logic               shot_v_q, shot_v_d;
  logic               hit_take;

  always_comb begin
    unique case ({move_left_i, move_right_i})
      2'b10:   move_st = LEFT;
      2'b01:   move_st = RIGHT;
      default: move_st = IDLE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    lives_d  = lives_q;
    cool_d   = cool_q;
    shot_v_d = shot_v_q;
    shot_x_d = shot_x_q;
    hit_take = 1'b0;

    if (frame_i && cool_q != '0) cool_d = cool_q - 1'b1;
    if (shot_v_q && shot_ready_i) begin
      shot_v_d = 1'b0;
      cool_d   = COOL_W;
    end

    case (state_q)
      IDLE, LEFT, RIGHT: begin
        // Borders compared in int so the step can never wrap the position bus.
        if (state_q == LEFT && frame_i)
          pos_d = (int'(pos_q) >= left_border_p + step_p) ? pos_q - STEP_W : LB_W;
        if (state_q == RIGHT && frame_i)
          pos_d = (int'(pos_q) + step_p <= RMAX) ? pos_q + STEP_W : RMAX_W;
        if (hit_i) begin
          hit_take = 1'b1;
          shot_v_d = 1'b0;
          if (lives_q != '0) begin
            lives_d = lives_q - 1'b1;
            state_d = HIT;
          end else begin
            state_d = DEAD;
          end
        end else begin
          state_d = move_st;
          if (shoot_i && cool_q == '0 && !shot_v_q) begin
            shot_v_d = 1'b1;
            shot_x_d = pos_q + HALF_W;
          end
        end
      end
      HIT: begin
        if (shoot_i) begin
          pos_d   = START_W;
          cool_d  = COOL_W;
          state_d = move_st;
        end
      end
      DEAD: begin
        if (shoot_i) begin
          lives_d = STARTL_W;
          pos_d   = START_W;
          cool_d  = COOL_W;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = START_W;
      end
    endcase

    if (add_life_i && frame_i && state_q != DEAD && !hit_take && lives_q < MAXL_W)
      lives_d = lives_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      pos_q    <= START_W;
      lives_q  <= STARTL_W;
      cool_q   <= '0;
      shot_v_q <= 1'b0;
      shot_x_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      lives_q  <= lives_d;
      cool_q   <= cool_d;
      shot_v_q <= shot_v_d;
      shot_x_q <= shot_x_d;
    end
  end

  assign shot_valid_o = shot_v_q;
  assign shot_x_o     = shot_x_q;
  assign alive_o      = (state_q != DEAD);
  assign paused_o     = (state_q == HIT);
  assign pos_left_o   = pos_q;
  assign pos_right_o  = pos_q + SW_W;
  assign lives_o      = lives_q;
  assign state_o      = state_q;

`ifdef PLAYER_CTRL_FLASH_EN
  localparam int FW = $clog2(flash_period_p+1);
  localparam logic [FW-1:0] FLAST_W = FW'(flash_period_p - 1);

  logic [FW-1:0] flash_q, flash_d;
  logic          vis_q, vis_d;

  always_comb begin
    flash_d = flash_q;
    vis_d   = vis_q;
    if (state_d != HIT) begin
      flash_d = '0;
      vis_d   = 1'b1;
    end else if (state_q == HIT && frame_i) begin
      if (flash_q == FLAST_W) begin
        flash_d = '0;
        vis_d   = ~vis_q;
      end else begin
        flash_d = flash_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      flash_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      flash_q <= flash_d;
      vis_q   <= vis_d;
    end
  end

  assign visible_o = vis_q;
`else
  assign visible_o = alive_o;
`endif

endmodule
